// File: rtl/uart_port_pkg.sv
// uart_port_pkg: shared definitions for the on-chip serial port.
//   - tx_state_e / rx_state_e : 2-bit state encodings of the TX and RX FSMs
//   - DEFAULT_CLKS_PER_BIT    : 50 MHz / 115200 baud
//   - ADDR_DATA / ADDR_STATUS : bus addresses decoded by the memory controller
//   - is_fall / is_rise       : edge tests on a registered (old, new) strobe pair
package uart_port_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [15:0] ADDR_DATA   = 16'hBF00;
  localparam logic [15:0] ADDR_STATUS = 16'hBF01;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_START = 2'd1,
    T_DATA  = 2'd2,
    T_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_e;

  function automatic logic is_fall(input logic old_v, input logic new_v);
    return old_v & ~new_v;
  endfunction

  function automatic logic is_rise(input logic old_v, input logic new_v);
    return ~old_v & new_v;
  endfunction

endpackage

// File: rtl/uart_port_if.sv
// uart_port_if: strobe bus between the CPU memory controller (master) and the
// serial port (slave).
//   rdn, wrn   : active-low read/write strobes, synchronous to the port clock
//   data_i     : byte written to the transmit holding register
//   data_o     : {8'h00, rbr}; data_oe enables the controller's bus driver
//   data_ready, tbre, tsre : status bits packed by the controller into 0xBF01
//
// Handshake: there is no valid/ready pair. A transfer is an edge of a strobe:
// a write happens on the falling edge of wrn and only takes effect when tbre is
// 1 (otherwise it is silently dropped); a read consumes the byte on the rising
// edge of rdn, which clears data_ready. The master must therefore poll tbre
// before writing and data_ready before reading.
interface uart_port_if;
  logic        rdn;
  logic        wrn;
  logic [7:0]  data_i;
  logic [15:0] data_o;
  logic        data_oe;
  logic        data_ready;
  logic        tbre;
  logic        tsre;

  modport master (
    output rdn, wrn, data_i,
    input  data_o, data_oe, data_ready, tbre, tsre
  );

  modport slave (
    input  rdn, wrn, data_i,
    output data_o, data_oe, data_ready, tbre, tsre
  );
endinterface

// File: rtl/uart_port_rx_core.sv
// uart_rx_core: 8N1 receiver.
//   clk_50MHz, rst : clock and asynchronous active-low reset
//   rxd            : asynchronous serial input
//   byte_valid     : one-cycle pulse; rx_byte takes the new byte on this edge
//   rx_byte        : receive buffer register (rbr)
//   rx_state_dbg   : current RX FSM state
module uart_rx_core
  import uart_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output rx_state_e  rx_state_dbg
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             rx_s1, rx_s2, rx_prev;
  rx_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       rbr;

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      state   <= R_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      rbr     <= '0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      if (byte_valid) rbr <= shift;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    byte_valid = 1'b0;
    case (state)
      R_IDLE: begin
        if (rx_prev && !rx_s2) begin
          state_n = R_START;
          cnt_n   = '0;
        end
      end
      R_START: begin
        // Half a bit in: a line that is high again was only a glitch.
        if (cnt == CNT_HALF) begin
          cnt_n     = '0;
          bit_cnt_n = '0;
          state_n   = rx_s2 ? R_IDLE : R_DATA;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      R_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          shift_n   = {rx_s2, shift[7:1]};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) state_n = R_STOP;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      R_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n      = '0;
          byte_valid = rx_s2;  // a low stop bit is a framing error: drop it
          state_n    = R_IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: state_n = R_IDLE;
    endcase
  end

  assign rx_byte      = rbr;
  assign rx_state_dbg = state;

endmodule

// File: rtl/uart_port.sv
// uart_port: on-chip serial port behind the memory controller's strobe bus.
//   clk_50MHz, rst : clock and asynchronous active-low reset
//   bus            : uart_port_if.slave (strobes, data, status)
//   rxd / txd      : serial input (asynchronous) / output (idle high), 8N1
//   tx_state_dbg   : current TX FSM state
//   rx_state_dbg   : current RX FSM state
module uart_port
  import uart_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  uart_port_if.slave  bus,
  input  logic        rxd,
  output logic        txd,
  output tx_state_e   tx_state_dbg,
  output rx_state_e   rx_state_dbg
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             wrn_r, wrn_d, rdn_r, rdn_d;
  logic             wr_accept, rd_rise;
  logic [7:0]       thr;
  logic             tbre, tsre, data_ready;
  tx_state_e        tx_state, tx_state_n;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
  logic [3:0]       tx_bit, tx_bit_n;
  logic [7:0]       tx_shift, tx_shift_n;
  logic             txd_n, tsre_n, tx_pickup;
  logic             rx_valid;
  logic [7:0]       rbr;

  // Edges are taken between two registered copies of each strobe, so a write
  // lands in thr two edges after wrn goes low and a read clears data_ready two
  // edges after rdn goes high.
  assign wr_accept = is_fall(wrn_d, wrn_r) & tbre;
  assign rd_rise   = is_rise(rdn_d, rdn_r);

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      wrn_r      <= 1'b1;
      wrn_d      <= 1'b1;
      rdn_r      <= 1'b1;
      rdn_d      <= 1'b1;
      thr        <= '0;
      tbre       <= 1'b1;
      tsre       <= 1'b1;
      txd        <= 1'b1;
      data_ready <= 1'b0;
      tx_state   <= T_IDLE;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_shift   <= '0;
    end else begin
      wrn_r    <= bus.wrn;
      wrn_d    <= wrn_r;
      rdn_r    <= bus.rdn;
      rdn_d    <= rdn_r;
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd      <= txd_n;
      tsre     <= tsre_n;
      // Pickup needs tbre=0 and a write needs tbre=1, so they never collide.
      if (tx_pickup)      tbre <= 1'b1;
      else if (wr_accept) tbre <= 1'b0;
      if (wr_accept) thr <= bus.data_i;
      // A byte arriving in the same cycle as the read outranks the clear.
      if (rx_valid)     data_ready <= 1'b1;
      else if (rd_rise) data_ready <= 1'b0;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    txd_n      = txd;
    tsre_n     = tsre;
    tx_pickup  = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if (!tbre) begin
          tx_pickup  = 1'b1;
          tx_shift_n = thr;
          txd_n      = 1'b0;
          tsre_n     = 1'b0;
          tx_cnt_n   = '0;
          tx_state_n = T_START;
        end
      end
      T_START: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          txd_n      = tx_shift[0];
          tx_state_n = T_DATA;
        end else begin
          tx_cnt_n = tx_cnt + CNT_ONE;
        end
      end
      T_DATA: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 4'd7) begin
            txd_n      = 1'b1;
            tx_state_n = T_STOP;
          end else begin
            tx_shift_n = {1'b0, tx_shift[7:1]};
            txd_n      = tx_shift[1];
            tx_bit_n   = tx_bit + 4'd1;
          end
        end else begin
          tx_cnt_n = tx_cnt + CNT_ONE;
        end
      end
      T_STOP: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          if (!tbre) begin
            // Next byte already waiting: start bit follows with no idle gap.
            tx_pickup  = 1'b1;
            tx_shift_n = thr;
            txd_n      = 1'b0;
            tx_state_n = T_START;
          end else begin
            tsre_n     = 1'b1;
            tx_state_n = T_IDLE;
          end
        end else begin
          tx_cnt_n = tx_cnt + CNT_ONE;
        end
      end
      default: tx_state_n = T_IDLE;
    endcase
  end

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_50MHz    (clk_50MHz),
    .rst          (rst),
    .rxd          (rxd),
    .byte_valid   (rx_valid),
    .rx_byte      (rbr),
    .rx_state_dbg (rx_state_dbg)
  );

  assign bus.data_o     = {8'h00, rbr};
  assign bus.data_oe    = ~bus.rdn;
  assign bus.data_ready = data_ready;
  assign bus.tbre       = tbre;
  assign bus.tsre       = tsre;
  assign tx_state_dbg   = tx_state;

endmodule

// File: tb/tb_uart_port.sv
// tb_uart_port: randomized self-checking bench for uart_port at 4 clocks/bit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_port;
  import uart_port_pkg::*;

  localparam int CPB = 4;

  // ---------------- clock / reset ----------------
  logic      clk_50MHz = 1'b0;
  logic      rst = 1'b0;
  logic      rxd = 1'b1;
  logic      txd;
  tx_state_e tx_dbg;
  rx_state_e rx_dbg;

  uart_port_if bus ();

  always #5 clk_50MHz = ~clk_50MHz;

  uart_port #(.CLKS_PER_BIT(CPB)) dut (
    .clk_50MHz    (clk_50MHz),
    .rst          (rst),
    .bus          (bus),
    .rxd          (rxd),
    .txd          (txd),
    .tx_state_dbg (tx_dbg),
    .rx_state_dbg (rx_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];      // bytes expected on txd, in order
  logic [7:0] m_rbr = 8'h00; // receive buffer as the host should see it
  logic       m_ready = 1'b0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected txd over one frame, one sample per clock, sample 0 in bit 0.
  function automatic logic [39:0] frame_wave(input logic [7:0] b);
    logic [39:0] w;
    logic [7:0]  t;
    logic        v;
    int          k;
    w = '0;
    for (int i = 0; i < 40; i++) begin
      k = i / CPB;
      if (k == 0)      v = 1'b0;
      else if (k == 9) v = 1'b1;
      else begin
        t = b >> (k - 1);
        v = t[0];
      end
      w = {v, w[39:1]};
    end
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk_50MHz);
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus.data_i = b;
    bus.wrn    = 1'b0;
    step();
    bus.wrn    = 1'b1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[0];
      f   = f >> 1;
      repeat (CPB) step();
    end
    rxd = 1'b1;
  endtask

  task automatic rx_done(input logic [7:0] b, input logic stop_bit);
    repeat (3) step();
    if (stop_bit) begin
      m_rbr   = b;
      m_ready = 1'b1;
    end
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_ready"}, 80'(bus.data_ready), 80'(m_ready));
    check({tag, "_data"}, 80'(bus.data_o), 80'({8'h00, m_rbr}));
  endtask

  task automatic read_port();
    bus.rdn = 1'b0;
    #1;
    check("rd_oe", 80'(bus.data_oe), 80'(1));
    check("rd_data", 80'(bus.data_o), 80'({8'h00, m_rbr}));
    step();
    bus.rdn = 1'b1;
    step();
    check("rd_ready_hold", 80'(bus.data_ready), 80'(m_ready));
    step();
    m_ready = 1'b0;
    check("rd_ready_clr", 80'(bus.data_ready), 80'(m_ready));
  endtask

  // ---------------- stimulus ----------------
  logic [39:0]  obs40;
  logic [119:0] obs;
  logic [7:0]   a, b, c;
  int           rb, n;
  logic         idle_ok, stop_bit;

  initial begin
    bus.rdn    = 1'b1;
    bus.wrn    = 1'b1;
    bus.data_i = 8'h00;
    repeat (3) step();
    check("rst_txd", 80'(txd), 80'(1));
    check("rst_tbre", 80'(bus.tbre), 80'(1));
    check("rst_tsre", 80'(bus.tsre), 80'(1));
    check("rst_ready", 80'(bus.data_ready), 80'(0));
    check("rst_data_o", 80'(bus.data_o), 80'(0));
    rst = 1'b1;
    repeat (2) step();

    // Single write of 0x55 with exact latency and frame length.
    write_byte(8'h55);
    check("w55_tbre_pre", 80'(bus.tbre), 80'(1));
    step();
    check("w55_tbre_full", 80'(bus.tbre), 80'(0));
    step();
    check("w55_tbre_empty", 80'(bus.tbre), 80'(1));
    check("w55_tsre_busy", 80'(bus.tsre), 80'(0));
    obs40 = '0;
    for (int i = 0; i < 40; i++) begin
      if (i != 0) step();
      obs40 = {txd, obs40[39:1]};
    end
    check("w55_wave", 80'(obs40), 80'(frame_wave(8'h55)));
    check("w55_tsre_at_39", 80'(bus.tsre), 80'(0));
    step();
    check("w55_tsre_at_40", 80'(bus.tsre), 80'(1));
    check("w55_txd_idle", 80'(txd), 80'(1));
    check("tx_fsm_idle", 80'(tx_dbg), 80'(T_IDLE));
    repeat (5) step();

    // Back-to-back frames; a third write while the holding register is full is lost.
    for (int it = 0; it < 3; it++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      c  = 8'($urandom);
      rb = $urandom_range(25, 2);
      exp_q.push_back(a);
      exp_q.push_back(b);
      write_byte(a);
      n = 0;
      while (txd !== 1'b0 && n < 10) begin
        step();
        n++;
      end
      check("b2b_start", 80'(txd), 80'(0));
      obs = '0;
      for (int cyc = 0; cyc < 120; cyc++) begin
        obs = {txd, obs[119:1]};
        if (cyc == rb) begin
          bus.data_i = b;
          bus.wrn    = 1'b0;
        end
        if (cyc == rb + 1) bus.wrn = 1'b1;
        if (cyc == rb + 3) begin
          check("b2b_tbre_full", 80'(bus.tbre), 80'(0));
          bus.data_i = c;
          bus.wrn    = 1'b0;
        end
        if (cyc == rb + 4) bus.wrn = 1'b1;
        step();
      end
      check("b2b_frame1", 80'(obs[39:0]), 80'(frame_wave(exp_q.pop_front())));
      check("b2b_frame2", 80'(obs[79:40]), 80'(frame_wave(exp_q.pop_front())));
      check("b2b_no_third", 80'(obs[119:80]), 80'({40{1'b1}}));
      check("b2b_tsre", 80'(bus.tsre), 80'(1));
    end

    // Receive 0xA3 and read it back.
    send_rx(8'hA3, 1'b1);
    rx_done(8'hA3, 1'b1);
    check_rx("rx_a3");
    read_port();
    check("rd_oe_off", 80'(bus.data_oe), 80'(0));

    // One-cycle glitch is not a start bit.
    rxd = 1'b0;
    step();
    rxd = 1'b1;
    repeat (50) step();
    check_rx("glitch");
    check("rx_fsm_idle", 80'(rx_dbg), 80'(R_IDLE));

    // Framing error: byte discarded, buffer untouched.
    send_rx(8'h3C, 1'b0);
    rx_done(8'h3C, 1'b0);
    check_rx("frame_err");

    // Overrun: the second byte replaces the unread first.
    send_rx(8'h11, 1'b1);
    rx_done(8'h11, 1'b1);
    check_rx("ovr_first");
    send_rx(8'h22, 1'b1);
    rx_done(8'h22, 1'b1);
    check_rx("ovr_second");
    read_port();

    // Random frames, random stop bit, random reads.
    for (int it = 0; it < 6; it++) begin
      a        = 8'($urandom);
      stop_bit = ($urandom_range(3, 0) != 0);
      send_rx(a, stop_bit);
      rx_done(a, stop_bit);
      check_rx("rx_rand");
      if ($urandom_range(1, 0) == 1) read_port();
    end

    // Load coincides with the rdn rise: the new byte stays flagged.
    send_rx(8'h5A, 1'b1);
    rx_done(8'h5A, 1'b1);
    check_rx("coin_pre");
    a = 8'($urandom);
    fork
      send_rx(a, 1'b1);
      begin
        repeat (38) step();
        bus.rdn = 1'b0;
        step();
        bus.rdn = 1'b1;
      end
    join
    rx_done(a, 1'b1);
    check_rx("coin");
    repeat (4) step();
    check_rx("coin_later");

    // Reset in the middle of a TX frame.
    write_byte(8'($urandom));
    repeat (15) step();
    rst = 1'b0;
    #1;
    m_ready = 1'b0;
    m_rbr   = 8'h00;
    check("mid_rst_txd", 80'(txd), 80'(1));
    check("mid_rst_tbre", 80'(bus.tbre), 80'(1));
    check("mid_rst_tsre", 80'(bus.tsre), 80'(1));
    check_rx("mid_rst");
    step();
    check("mid_rst_txd_held", 80'(txd), 80'(1));
    rst = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (txd !== 1'b1 || bus.tsre !== 1'b1 || bus.tbre !== 1'b1) idle_ok = 1'b0;
    end
    check("post_rst_no_frame", 80'(idle_ok), 80'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_port.md
# uart_port

Serial-port responder that sits on the far side of the CPU memory controller's `rdn`/`wrn` strobe interface, mapped at 0xBF00 (data) and 0xBF01 (status). It accepts byte writes and serialises them as 8N1 frames on `txd`. It deserialises 8N1 frames from `rxd` into a receive buffer. It reports `tbre`/`tsre`/`data_ready` in the status form the controller already packs into 0xBF01. It replaces the external UART so the design runs with an on-chip serial port.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200 baud). Must be ≥ 4.
- `clk_50MHz`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rdn`  in  1  read strobe, active low; synchronous to `clk_50MHz`.
- `wrn`  in  1  write strobe, active low; synchronous to `clk_50MHz`.
- `data_i`  in  8  write byte (low byte of the data bus).
- `data_o`  out  16  read data `{8'h00, rbr}`.
- `data_oe`  out  1  combinational `~rdn`; bus driver enable for `data_o`.
- `data_ready`  out  1  receive buffer holds an unread byte.
- `tbre`  out  1  transmit holding register empty.
- `tsre`  out  1  transmit shift register empty (line idle).
- `rxd`  in  1  serial input, asynchronous.
- `txd`  out  1  serial output, idle high.

## Operation
- Reset values: `txd`=1, `tbre`=1, `tsre`=1, `data_ready`=0, `data_o`=0, `thr`=0, `rbr`=0. Both FSMs go to IDLE. Reset mid-frame aborts the frame and raises `txd` immediately.
- Strobes are registered every cycle. A fall is old=1, new=0; a rise is old=0, new=1.
- **Write:**
  - On a `wrn` fall with `tbre`=1: load `thr` ← `data_i` and clear `tbre`.
  - On a `wrn` fall with `tbre`=0: drop the write with no state change.
- **TX FSM** (T_IDLE, T_START, T_DATA, T_STOP):
  - In T_IDLE with `tbre`=0: move `thr` into the shifter, set `tbre`=1 and `tsre`=0, drive `txd`=0, go to T_START.
  - The start bit, 8 data bits (LSB first) and the stop bit (1) each last `CLKS_PER_BIT` cycles.
  - At the end of T_STOP:
    - if `tbre`=0, go straight to T_START with the next byte; no idle gap and `tsre` stays 0;
    - otherwise set `tsre`=1 and go to T_IDLE.
- **RX FSM** (R_IDLE, R_START, R_DATA, R_STOP), using a 2-flop synchroniser on `rxd`:
  - R_IDLE: a synchronised 1→0 transition enters R_START.
  - R_START: after `CLKS_PER_BIT/2` cycles, re-sample the line. If it is 1, treat it as a false start and return to R_IDLE.
  - R_DATA: sample 8 bits at bit centres, spaced `CLKS_PER_BIT` apart, LSB first.
  - R_STOP: sample the stop bit at its centre.
    - Stop=1: load `rbr` and set `data_ready`=1. If `data_ready` was already 1, overwrite `rbr` (overrun; no flag).
    - Stop=0: framing error; discard the byte and leave `data_ready` unchanged.
  - Return to R_IDLE in all cases.
- **Read:**
  - `data_o` reflects `rbr` at all times.
  - A `rdn` rise clears `data_ready`.
  - If a `rdn` rise and an RX byte load happen in the same cycle, the load wins: `data_ready` stays 1 with the new `rbr`.
- A simultaneous `wrn` fall and TX FSM `thr` pickup in the same cycle cannot occur (pickup requires `tbre`=0, write requires `tbre`=1).

## Timing
- Write to line: `wrn` fall registered at edge N → `tbre`=0 after N+1 → `txd`=0, `tbre`=1, `tsre`=0 after N+2.
- Frame length is exactly 10·`CLKS_PER_BIT` cycles. `tsre` rises on the edge that ends the stop bit.
- RX latency: `data_ready` rises 1 cycle after the stop-bit centre sample, i.e. ≈9.5·`CLKS_PER_BIT` + 3 cycles after the start edge on `rxd`.
- `data_ready` clears 1 cycle after the `rdn` rise is registered.
- Counters: bit counter is 4 bits; cycle counter is $clog2(`CLKS_PER_BIT`) bits and wraps to 0 at `CLKS_PER_BIT`-1.

## Structure
- Shared `define.v` holds:
  - TX/RX state encodings (2-bit);
  - the default `CLKS_PER_BIT`;
  - the 0xBF00/0xBF01 address constants.
- One sub-module, `uart_rx_core`, contains the synchroniser, RX FSM and `rbr`, and outputs `byte_valid` for one cycle plus the `byte` itself. `data_ready` and the TX path remain in `uart_port`.

## Test plan (`CLKS_PER_BIT`=4)
- Reset asserted mid-TX-frame → `txd`=1, `tbre`=1, `tsre`=1, `data_ready`=0 while `rst`=0; after release, no residual frame.
- Write 0x55 → `txd` = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; `tbre`=1 two cycles after the `wrn` fall; `tsre`=1 exactly 40 cycles after `txd` falls.
- Two writes, the second while frame 1 is in flight → 20 contiguous bit-times with no idle; a third write while `tbre`=0 is dropped (only 2 frames appear).
- Drive 0xA3 on `rxd` at 4 cycles/bit → `data_ready`=1; a `rdn` pulse gives `data_o`=0x00A3 and `data_ready`=0 one cycle after `rdn` rises.
- `rxd` glitched low for 1 cycle → no byte; a frame of 0x3C with stop bit 0 → `data_ready` stays 0 and `rbr` is unchanged.
- Byte 0x11 received and unread, then 0x22 received → `data_ready`=1 and `data_o`=0x0022. Byte load coincident with the `rdn` rise → `data_ready` stays 1.
